// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The optional parity helper is only used when IMEM_PARITY_EN is defined.
package imem_pkg;

    localparam int          IMEM_ADDR_W = 12;
    localparam int          IMEM_DATA_W = 32;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

    localparam imem_rsp_t RSP_IDLE = '{data: INSTR_NOP, err: 1'b0};

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [IMEM_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response handshake between the fetch stage (master)
// and the instruction-memory responder (slave).
interface imem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_rsp_fifo.sv
// In-order response buffer with registered output valid/data. The producer
// must only push when space is known to exist (or a pop happens in the same cycle).
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  imem_rsp_t                  push_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output imem_rsp_t                  out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    imem_rsp_t        store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             out_valid_r;
    imem_rsp_t        out_data_r;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] wr_ptr_nx_s;
    logic [PTR_W-1:0] rd_ptr_nx_s;
    logic [CNT_W-1:0] count_nx_s;
    imem_rsp_t        out_data_nx_s;

    // Next-state pointers, occupancy and the head word the output register will hold.
    always_comb begin
        pop_s         = out_valid_r && out_ready;
        push_s        = push_valid && ((count_r != CNT_MAX) || pop_s);
        wr_ptr_nx_s   = wr_ptr_r;
        rd_ptr_nx_s   = rd_ptr_r;
        count_nx_s    = count_r;
        out_data_nx_s = RSP_IDLE;

        if (push_s) begin
            wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase

        // A push into an otherwise-empty buffer lands straight at the head.
        if (count_nx_s == '0) begin
            out_data_nx_s = RSP_IDLE;
        end else if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            out_data_nx_s = push_data;
        end else begin
            out_data_nx_s = store_r[rd_ptr_nx_s];
        end
    end

    // Buffer storage, pointers, occupancy and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= RSP_IDLE;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= RSP_IDLE;
        end else begin
            if (push_s) begin
                store_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            count_r     <= count_nx_s;
            out_valid_r <= (count_nx_s != '0);
            out_data_r  <= out_data_nx_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign count     = count_r;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program store with side load port, one read
// stage and an in-order response buffer. Define IMEM_PARITY_EN to add per-word parity.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    imem_responder_if.slave   bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
`ifdef IMEM_PARITY_EN
    logic              mem_par_r [2**ADDR_W];
    logic              stage_par_r;
`endif

    logic              req_ready_r;
    logic              stage_valid_r;
    logic [DATA_W-1:0] stage_data_r;
    logic              stage_oor_r;

    logic              accept_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [OCC_W-1:0]  occ_nx_s;
    imem_rsp_t         stage_rsp_s;
    imem_rsp_t         fifo_out_s;
    logic              fifo_valid_s;

    assign accept_s   = bus.req_valid && req_ready_r;
    assign in_range_s = (bus.req_addr[31:ADDR_W] == '0);
    assign word_idx_s = bus.req_addr[ADDR_W-1:0];
    assign pop_s      = fifo_valid_s && bus.rsp_ready;

    // Program store load port; content survives reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
            mem_par_r[ld_addr] <= even_parity(ld_data);
`endif
        end
    end

    // Read stage: a nonblocking read here sees the word as it was before a same-edge load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid_r <= 1'b0;
            stage_data_r  <= INSTR_NOP;
            stage_oor_r   <= 1'b0;
`ifdef IMEM_PARITY_EN
            stage_par_r   <= 1'b0;
`endif
        end else begin
            stage_valid_r <= accept_s;
            if (accept_s) begin
                if (in_range_s) begin
                    stage_data_r <= mem_r[word_idx_s];
`ifdef IMEM_PARITY_EN
                    stage_par_r  <= mem_par_r[word_idx_s];
`endif
                end else begin
                    stage_data_r <= INSTR_NOP;
`ifdef IMEM_PARITY_EN
                    stage_par_r  <= 1'b0;
`endif
                end
                stage_oor_r <= !in_range_s;
            end
        end
    end

    // Substitute a NOP with err set for out-of-range (and, if enabled, corrupted) words.
    always_comb begin
        stage_rsp_s = RSP_IDLE;
        if (stage_oor_r) begin
            stage_rsp_s = '{data: INSTR_NOP, err: 1'b1};
`ifdef IMEM_PARITY_EN
        end else if (even_parity(stage_data_r) != stage_par_r) begin
            stage_rsp_s = '{data: INSTR_NOP, err: 1'b1};
`endif
        end else begin
            stage_rsp_s = '{data: stage_data_r, err: 1'b0};
        end
    end

    // Occupancy after this edge; pops only free space from the next cycle on.
    always_comb begin
        occ_nx_s = OCC_W'(fifo_count_s) + OCC_W'(stage_valid_r)
                 + OCC_W'(accept_s) - OCC_W'(pop_s);
    end

    // Registered request-ready, low throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r <= 1'b0;
        end else begin
            req_ready_r <= (occ_nx_s < OCC_LIMIT);
        end
    end

    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (stage_valid_r),
        .push_data  (stage_rsp_s),
        .out_valid  (fifo_valid_s),
        .out_ready  (bus.rsp_ready),
        .out_data   (fifo_out_s),
        .count      (fifo_count_s)
    );

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = fifo_valid_s;
    assign bus.rsp_data  = fifo_out_s.data;
    assign bus.rsp_err   = fifo_out_s.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: reset, latency, backpressure, range,
// load/read collision, mid-operation reset, and parity when IMEM_PARITY_EN is defined.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    imem_responder_if #(.DATA_W(32)) bus ();

    imem_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_mem [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Single fetch with rsp_ready held high; every wait is bounded.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output logic ok);
        ok = 1'b0; d = 32'hDEAD_BEEF; e = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = a;
        for (int i = 0; i < 10 && !bus.req_ready; i++) tick();
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) begin
                d = bus.rsp_data; e = bus.rsp_err; ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic        ok;
        logic        acc;
        int          acc_cnt;
        int          next_req;
        int          got;

        reset = 1'b1; ld_en = 1'b0; ld_addr = 12'd0; ld_data = 32'd0;
        bus.req_valid = 1'b0; bus.req_addr = 32'd0; bus.rsp_ready = 1'b0;
        exp_mem[0] = 32'h2002_0005; exp_mem[1] = 32'h0000_0820;
        exp_mem[2] = 32'h1000_0002; exp_mem[3] = 32'h1000_0003;
        exp_mem[4] = 32'h1000_0004; exp_mem[5] = 32'h1000_0005;

        // Reset state
        tick(); tick();
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("rel_req_ready_high", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) load(12'(i), exp_mem[i]);

        // Back-to-back fetch and 2-cycle latency
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        tick();
        check("lat_no_rsp_yet", {31'd0, bus.rsp_valid}, 32'd0);
        bus.req_addr = 32'd1;
        tick();
        bus.req_valid = 1'b0;
        check("lat_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("b2b_data0", bus.rsp_data, 32'h2002_0005);
        check("b2b_err0", {31'd0, bus.rsp_err}, 32'd0);
        tick();
        check("b2b_valid1", {31'd0, bus.rsp_valid}, 32'd1);
        check("b2b_data1", bus.rsp_data, 32'h0000_0820);
        tick();
        check("b2b_drained", {31'd0, bus.rsp_valid}, 32'd0);

        // Backpressure
        bus.rsp_ready = 1'b0;
        next_req = 0; acc_cnt = 0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        for (int c = 0; c < 6; c++) begin
            acc = bus.req_valid && bus.req_ready;
            if (acc) acc_cnt++;
            tick();
            if (acc) begin
                next_req++;
                bus.req_addr = 32'(next_req);
            end
        end
        check("bp_accepts", 32'(acc_cnt), 32'd2);
        check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("bp_head", bus.rsp_data, exp_mem[0]);
        tick();
        check("bp_head_stable", bus.rsp_data, exp_mem[0]);
        check("bp_still_blocked", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            acc = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) begin
                check("bp_order", bus.rsp_data, exp_mem[got]);
                got++;
            end
            tick();
            if (acc) begin
                next_req++;
                bus.req_addr = 32'(next_req);
                if (next_req == 6) bus.req_valid = 1'b0;
            end
        end
        check("bp_all_served", 32'(got), 32'd6);
        tick(); tick();
        check("bp_no_extra", {31'd0, bus.rsp_valid}, 32'd0);

        // Out-of-range address, then in-range
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_1000;
        tick();
        bus.req_addr = 32'd0;
        tick();
        bus.req_valid = 1'b0;
        check("oor_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("oor_data", bus.rsp_data, 32'h0000_0000);
        check("oor_err", {31'd0, bus.rsp_err}, 32'd1);
        tick();
        check("after_oor_data", bus.rsp_data, 32'h2002_0005);
        check("after_oor_err", {31'd0, bus.rsp_err}, 32'd0);
        tick();

        // Same-edge load and read of one address
        load(12'd3, 32'hAAAA_AAAA);
        ld_en = 1'b1; ld_addr = 12'd3; ld_data = 32'h5555_5555;
        bus.req_valid = 1'b1; bus.req_addr = 32'd3;
        tick();
        ld_en = 1'b0; bus.req_valid = 1'b0;
        tick();
        check("coll_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("coll_old_word", bus.rsp_data, 32'hAAAA_AAAA);
        tick();
        fetch(32'd3, d, e, ok);
        check("coll_refetch_ok", {31'd0, ok}, 32'd1);
        check("coll_new_word", d, 32'h5555_5555);

        // Asynchronous reset with two responses buffered
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        tick();
        bus.req_addr = 32'd1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("pre_rst_buffered", {31'd0, bus.rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("async_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("post_rst_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
        end

`ifdef IMEM_PARITY_EN
        // Corrupted stored word
        load(12'd7, 32'h1234_5678);
        dut.mem_r[7] = dut.mem_r[7] ^ 32'h0000_0001;
        fetch(32'd7, d, e, ok);
        check("par_ok", {31'd0, ok}, 32'd1);
        check("par_data", d, 32'h0000_0000);
        check("par_err", {31'd0, e}, 32'd1);
        fetch(32'd1, d, e, ok);
        check("par_clean_data", d, 32'h0000_0820);
        check("par_clean_err", {31'd0, e}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
